// File: rtl/ir_frame_receiver.sv
// ir_frame_receiver
//   Receives NEC-format IR frames from a demodulated receiver output. Pulse
//   and space durations are measured in prescaled ticks, classified against
//   the NEC timing windows, and assembled into a 32-bit frame. The frame is
//   checked (command byte against its inverse, optionally the address). A
//   valid command byte is then held on cmd for the downstream command
//   decoder. Repeat codes and stalled frames are also handled.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   ir_in         demodulated IR input, idles high, 0 = mark (asynchronous)
//   cmd           last valid command byte, held until the next valid frame
//   cmd_valid     one-clk pulse when cmd is updated
//   repeat_pulse  one-clk pulse on a valid repeat code after a valid frame
//   frame_err     one-clk pulse on timing/checksum/address/timeout failure
//   busy          high while a frame or repeat code is in progress
module ir_frame_receiver #(
  parameter int         DIV        = 2812,
  parameter logic [7:0] ADDR       = 8'h00,
  parameter bit         CHECK_ADDR = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ir_in,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       repeat_pulse,
  output logic       frame_err,
  output logic       busy
);

  localparam int            PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
  localparam logic [7:0]    DUR_TIMEOUT = 8'd200;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_REP_MARK   = 3'd5,
    S_CHECK      = 3'd6
  } state_t;

  // Inclusive window test on a measured duration.
  function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Frame integrity: command byte must match its inverse; the address is
  // checked only when enabled. The inverted address byte is ignored so that
  // extended-NEC remotes are accepted.
  function automatic logic frame_ok(input logic [31:0] w);
    logic chk_ok;
    logic addr_ok;
    chk_ok  = (w[31:24] == ~w[23:16]);
    addr_ok = (CHECK_ADDR == 1'b0) || (w[7:0] == ADDR);
    return chk_ok && addr_ok;
  endfunction

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    dur_q, dur_d;
  state_t        state_q, state_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          have_q, have_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          rep_q, rep_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic tick_s, rise_s, fall_s, edge_s, timeout_s;
  logic fail_s, bit_s;

  // Edges are taken from the second synchronizer stage against a third,
  // registered copy, so every edge is seen for exactly one cycle.
  assign rise_s    = sync2_q & ~prev_q;
  assign fall_s    = ~sync2_q & prev_q;
  assign edge_s    = rise_s | fall_s;
  assign timeout_s = (dur_q >= DUR_TIMEOUT);

  // Front end: synchronizer, free-running prescaler, saturating duration counter.
  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_s  = (presc_q == PRESC_LAST);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // An edge ends the level being timed, so it wins over a coincident tick.
    if (edge_s) begin
      dur_d = 8'd0;
    end else if (tick_s && (dur_q != 8'hFF)) begin
      dur_d = dur_q + 8'd1;
    end else begin
      dur_d = dur_q;
    end
  end

  // Frame FSM: classify each completed level and assemble/check the frame.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    have_d      = have_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    rep_d       = 1'b0;
    err_d       = 1'b0;
    fail_s      = 1'b0;
    bit_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          state_d = S_LEAD_MARK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD_MARK: begin
        if (edge_s) begin
          if (rise_s && in_win(dur_q, 8'd144, 8'd176)) begin
            state_d = S_LEAD_SPACE;
          end else begin
            fail_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LEAD_SPACE: begin
        if (edge_s) begin
          if (fall_s && in_win(dur_q, 8'd72, 8'd88)) begin
            state_d  = S_BIT_MARK;
            bitcnt_d = 6'd0;
          end else if (fall_s && in_win(dur_q, 8'd32, 8'd48)) begin
            state_d = S_REP_MARK;
          end else begin
            fail_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_BIT_MARK: begin
        if (edge_s) begin
          if (rise_s && in_win(dur_q, 8'd7, 8'd13)) begin
            // The mark after the 32nd bit is the stop mark.
            if (bitcnt_q < 6'd32) begin
              state_d = S_BIT_SPACE;
            end else begin
              state_d = S_CHECK;
            end
          end else begin
            fail_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_BIT_SPACE: begin
        if (edge_s) begin
          if (fall_s && in_win(dur_q, 8'd7, 8'd13)) begin
            bit_s = 1'b0;
          end else if (fall_s && in_win(dur_q, 8'd25, 8'd35)) begin
            bit_s = 1'b1;
          end else begin
            fail_s = 1'b1;
          end
          // NEC sends LSB first: shift in from the top.
          shreg_d  = {bit_s, shreg_q[31:1]};
          bitcnt_d = bitcnt_q + 6'd1;
          state_d  = S_BIT_MARK;
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_REP_MARK: begin
        if (edge_s) begin
          if (rise_s && in_win(dur_q, 8'd7, 8'd13)) begin
            state_d = S_IDLE;
            rep_d   = have_q;
          end else begin
            fail_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (frame_ok(shreg_q)) begin
          cmd_d       = shreg_q[23:16];
          cmd_valid_d = 1'b1;
          have_d      = 1'b1;
        end else begin
          fail_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Any failure abandons the frame and forgets the last good one, so a
    // repeat code after an error is not honoured.
    if (fail_s) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      have_d  = 1'b0;
    end else begin
      err_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      presc_q     <= '0;
      dur_q       <= 8'd0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 6'd0;
      shreg_q     <= 32'd0;
      have_q      <= 1'b0;
      cmd_q       <= 8'd0;
      cmd_valid_q <= 1'b0;
      rep_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      presc_q     <= presc_d;
      dur_q       <= dur_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      have_q      <= have_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rep_q       <= rep_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd          = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign repeat_pulse = rep_q;
  assign frame_err    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ir_frame_receiver.sv
// tb_ir_frame_receiver
//   Drives NEC bursts with randomized (in-window) timing and random payloads
//   into two receivers sharing one input: instance 0 accepts any address,
//   instance 1 only accepts address 8'h04. A frame-level model predicts the
//   strobe counts and the held command for each instance.
module tb_ir_frame_receiver;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ir_in = 1'b1;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] cv, rp, fe, bz;

  ir_frame_receiver #(.DIV(DIV), .ADDR(8'h00), .CHECK_ADDR(1'b0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .cmd(cmd_a),
    .cmd_valid(cv[0]), .repeat_pulse(rp[0]), .frame_err(fe[0]), .busy(bz[0])
  );

  ir_frame_receiver #(.DIV(DIV), .ADDR(8'h04), .CHECK_ADDR(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .cmd(cmd_b),
    .cmd_valid(cv[1]), .repeat_pulse(rp[1]), .frame_err(fe[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observed strobe counts and protocol violations.
  int obs_v[2] = '{0, 0};
  int obs_r[2] = '{0, 0};
  int obs_e[2] = '{0, 0};
  int viol = 0;
  logic [1:0] cv_p = 2'b00, rp_p = 2'b00, fe_p = 2'b00;
  logic [7:0] cmd_pa = 8'h00, cmd_pb = 8'h00;
  logic [1:0] excl_bad, wide_bad, cmd_bad;

  assign excl_bad = (cv & rp) | (cv & fe) | (rp & fe);
  assign wide_bad = (cv & cv_p) | (rp & rp_p) | (fe & fe_p);
  assign cmd_bad  = {reset_n && !cv[1] && (cmd_b != cmd_pb),
                     reset_n && !cv[0] && (cmd_a != cmd_pa)};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      obs_v[k] <= obs_v[k] + int'(cv[k]);
      obs_r[k] <= obs_r[k] + int'(rp[k]);
      obs_e[k] <= obs_e[k] + int'(fe[k]);
    end
    viol   <= viol + $countones(excl_bad) + $countones(wide_bad) + $countones(cmd_bad);
    cv_p   <= cv;
    rp_p   <= rp;
    fe_p   <= fe;
    cmd_pa <= cmd_a;
    cmd_pb <= cmd_b;
  end

  // Frame-level reference model.
  int         exp_v[2] = '{0, 0};
  int         exp_r[2] = '{0, 0};
  int         exp_e[2] = '{0, 0};
  logic [7:0] exp_cmd[2] = '{8'h00, 8'h00};
  bit         exp_have[2] = '{1'b0, 1'b0};

  function automatic void model_frame(input logic [7:0] a, input logic [7:0] c,
                                      input logic [7:0] nc);
    for (int k = 0; k < 2; k++) begin
      if ((nc == ~c) && (k == 0 || a == 8'h04)) begin
        exp_v[k]++;
        exp_cmd[k]  = c;
        exp_have[k] = 1'b1;
      end else begin
        exp_e[k]++;
        exp_have[k] = 1'b0;
      end
    end
  endfunction

  function automatic void model_repeat();
    for (int k = 0; k < 2; k++) begin
      if (exp_have[k]) exp_r[k]++;
    end
  endfunction

  function automatic void model_error();
    for (int k = 0; k < 2; k++) begin
      exp_e[k]++;
      exp_have[k] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_cmd[k]  = 8'h00;
      exp_have[k] = 1'b0;
    end
  endfunction

  // Stimulus primitives (timing in ticks).
  task automatic hold(input logic lvl, input int ticks);
    ir_in = lvl;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  task automatic send_lead();
    hold(1'b0, $urandom_range(158, 162));
    hold(1'b1, $urandom_range(78, 82));
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, $urandom_range(9, 11));
      hold(1'b1, w[i] ? $urandom_range(28, 32) : $urandom_range(9, 11));
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                            input logic [7:0] c, input logic [7:0] nc);
    send_lead();
    send_bits({nc, c, na, a}, 32);
    hold(1'b0, $urandom_range(9, 11));
    hold(1'b1, 20);
  endtask

  task automatic send_repeat();
    hold(1'b0, $urandom_range(158, 162));
    hold(1'b1, $urandom_range(39, 41));
    hold(1'b0, $urandom_range(9, 11));
    hold(1'b1, 20);
  endtask

  task automatic test_reset();
    vectors++; if (cmd_a !== 8'h00) begin miscompares++; $display("FAIL reset_cmd_a: got %h expected 00", cmd_a); end
    vectors++; if (cmd_b !== 8'h00) begin miscompares++; $display("FAIL reset_cmd_b: got %h expected 00", cmd_b); end
    vectors++; if (cv !== 2'b00) begin miscompares++; $display("FAIL reset_cmd_valid: got %b expected 00", cv); end
    vectors++; if (rp !== 2'b00) begin miscompares++; $display("FAIL reset_repeat: got %b expected 00", rp); end
    vectors++; if (fe !== 2'b00) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 00", fe); end
    vectors++; if (bz !== 2'b00) begin miscompares++; $display("FAIL reset_busy: got %b expected 00", bz); end
  endtask

  task automatic test_nominal();
    send_lead();
    vectors++; if (bz !== 2'b11) begin miscompares++; $display("FAIL nominal_busy_mid: got %b expected 11", bz); end
    send_bits({8'h42, 8'hBD, 8'hFF, 8'h00}, 32);
    hold(1'b0, 10);
    hold(1'b1, 20);
    model_frame(8'h00, 8'hBD, 8'h42);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL nominal_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
      vectors++; if (obs_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL nominal_err_cnt[%0d]: got %0d expected %0d", k, obs_e[k], exp_e[k]); end
    end
    vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL nominal_cmd_a: got %h expected %h", cmd_a, exp_cmd[0]); end
    vectors++; if (cmd_b !== exp_cmd[1]) begin miscompares++; $display("FAIL nominal_cmd_b: got %h expected %h", cmd_b, exp_cmd[1]); end
    vectors++; if (bz !== 2'b00) begin miscompares++; $display("FAIL nominal_busy_end: got %b expected 00", bz); end
  endtask

  task automatic test_repeat();
    send_repeat();
    model_repeat();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_r[k] !== exp_r[k]) begin miscompares++; $display("FAIL repeat_cnt[%0d]: got %0d expected %0d", k, obs_r[k], exp_r[k]); end
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL repeat_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
    end
    vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL repeat_cmd_a: got %h expected %h", cmd_a, exp_cmd[0]); end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'h00, 8'hFF, 8'h6D, 8'h93);
    model_frame(8'h00, 8'h6D, 8'h93);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL badsum_err_cnt[%0d]: got %0d expected %0d", k, obs_e[k], exp_e[k]); end
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL badsum_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
    end
    vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL badsum_cmd_a: got %h expected %h", cmd_a, exp_cmd[0]); end
    send_repeat();
    model_repeat();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_r[k] !== exp_r[k]) begin miscompares++; $display("FAIL badsum_repeat_cnt[%0d]: got %0d expected %0d", k, obs_r[k], exp_r[k]); end
    end
  endtask

  task automatic test_short_lead();
    hold(1'b0, 130);
    hold(1'b1, 80);
    model_error();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL shortlead_err_cnt[%0d]: got %0d expected %0d", k, obs_e[k], exp_e[k]); end
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL shortlead_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
      vectors++; if (obs_r[k] !== exp_r[k]) begin miscompares++; $display("FAIL shortlead_repeat_cnt[%0d]: got %0d expected %0d", k, obs_r[k], exp_r[k]); end
    end
    vectors++; if (bz !== 2'b00) begin miscompares++; $display("FAIL shortlead_busy: got %b expected 00", bz); end
  endtask

  task automatic test_timeout();
    send_lead();
    send_bits({8'h55, 8'hAA, 8'h0F, 8'h3C}, 10);
    hold(1'b0, 230);
    model_error();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL timeout_err_cnt[%0d]: got %0d expected %0d", k, obs_e[k], exp_e[k]); end
    end
    vectors++; if (bz !== 2'b00) begin miscompares++; $display("FAIL timeout_busy: got %b expected 00", bz); end
    hold(1'b1, 20);
    send_frame(8'h04, 8'hFB, 8'h1D, 8'hE2);
    model_frame(8'h04, 8'h1D, 8'hE2);
    vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL timeout_next_cmd_a: got %h expected %h", cmd_a, exp_cmd[0]); end
    vectors++; if (cmd_b !== exp_cmd[1]) begin miscompares++; $display("FAIL timeout_next_cmd_b: got %h expected %h", cmd_b, exp_cmd[1]); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL timeout_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] c;
    send_lead();
    send_bits({8'hFF, 8'h00, 8'hFB, 8'h04}, 20);
    ir_in = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    vectors++; if (bz !== 2'b11) begin miscompares++; $display("FAIL rstmid_busy_before: got %b expected 11", bz); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (cmd_a !== 8'h00 || cmd_b !== 8'h00) begin miscompares++; $display("FAIL rstmid_cmd: got %h/%h expected 00/00", cmd_a, cmd_b); end
    vectors++; if ({cv, rp, fe, bz} !== 8'h00) begin miscompares++; $display("FAIL rstmid_strobes: got %b expected 00000000", {cv, rp, fe, bz}); end
    @(negedge clk);
    ir_in = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    hold(1'b1, 20);
    c = 8'($urandom_range(0, 255));
    send_frame(8'h04, 8'hFB, c, ~c);
    model_frame(8'h04, c, ~c);
    vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL rstmid_after_cmd_a: got %h expected %h", cmd_a, exp_cmd[0]); end
    vectors++; if (cmd_b !== exp_cmd[1]) begin miscompares++; $display("FAIL rstmid_after_cmd_b: got %h expected %h", cmd_b, exp_cmd[1]); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL rstmid_valid_cnt[%0d]: got %0d expected %0d", k, obs_v[k], exp_v[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, c, nc;
    for (int n = 0; n < 4; n++) begin
      a  = ($urandom_range(0, 1) == 1) ? 8'h04 : 8'($urandom_range(0, 255));
      c  = 8'($urandom_range(0, 255));
      nc = ~c;
      if ($urandom_range(0, 2) == 0) nc = nc ^ (8'h01 << $urandom_range(0, 7));
      send_frame(a, ~a, c, nc);
      model_frame(a, c, nc);
      if ($urandom_range(0, 1) == 1) begin
        send_repeat();
        model_repeat();
      end
      for (int k = 0; k < 2; k++) begin
        vectors++; if (obs_v[k] !== exp_v[k]) begin miscompares++; $display("FAIL b2b%0d_valid_cnt[%0d]: got %0d expected %0d", n, k, obs_v[k], exp_v[k]); end
        vectors++; if (obs_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL b2b%0d_err_cnt[%0d]: got %0d expected %0d", n, k, obs_e[k], exp_e[k]); end
        vectors++; if (obs_r[k] !== exp_r[k]) begin miscompares++; $display("FAIL b2b%0d_repeat_cnt[%0d]: got %0d expected %0d", n, k, obs_r[k], exp_r[k]); end
      end
      vectors++; if (cmd_a !== exp_cmd[0]) begin miscompares++; $display("FAIL b2b%0d_cmd_a: got %h expected %h", n, cmd_a, exp_cmd[0]); end
      vectors++; if (cmd_b !== exp_cmd[1]) begin miscompares++; $display("FAIL b2b%0d_cmd_b: got %h expected %h", n, cmd_b, exp_cmd[1]); end
    end
  endtask

  initial begin
    ir_in   = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    #2 reset_n = 1'b1;
    @(negedge clk);
    hold(1'b1, 10);
    test_nominal();
    test_repeat();
    test_bad_checksum();
    test_short_lead();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    vectors++; if (viol !== 0) begin miscompares++; $display("FAIL strobe_protocol: got %0d violations expected 0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
